// File: rtl/rambus_arbiter_if.sv
// rambus_arbiter_if: upstream Wishbone master bundle plus the downstream rambus (OpenRAM port B) nets
interface rambus_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 10
);
   logic [NUM_MASTERS-1:0]            m_active_i;
   logic [NUM_MASTERS-1:0]            m_cyc_i;
   logic [NUM_MASTERS-1:0]            m_stb_i;
   logic [NUM_MASTERS-1:0]            m_we_i;
   logic [4*NUM_MASTERS-1:0]          m_sel_i;
   logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_adr_i;
   logic [32*NUM_MASTERS-1:0]         m_dat_i;
   logic [NUM_MASTERS-1:0]            m_ack_o;
   logic [NUM_MASTERS-1:0]            m_err_o;
   logic [31:0]                       m_dat_o;
   logic                              rambus_wb_cyc_o;
   logic                              rambus_wb_stb_o;
   logic                              rambus_wb_we_o;
   logic [3:0]                        rambus_wb_sel_o;
   logic [ADDR_WIDTH-1:0]             rambus_wb_adr_o;
   logic [31:0]                       rambus_wb_dat_o;
   logic                              rambus_wb_ack_i;
   logic [31:0]                       rambus_wb_dat_i;
   modport slave (
      input  m_active_i, m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      input  rambus_wb_ack_i, rambus_wb_dat_i,
      output m_ack_o, m_err_o, m_dat_o,
      output rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_adr_o, rambus_wb_dat_o
   );
   modport master (
      output m_active_i, m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      output rambus_wb_ack_i, rambus_wb_dat_i,
      input  m_ack_o, m_err_o, m_dat_o,
      input  rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_adr_o, rambus_wb_dat_o
   );
endinterface

// File: rtl/rambus_arbiter.sv
// rambus_arbiter: round-robin Wishbone arbiter sharing OpenRAM port B between gated masters, with bus timeout
module rambus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic            wb_clk_i,
   input logic            wb_rst_i,
   rambus_arbiter_if.slave bus
);
   localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
   localparam int KW = IW + 1;
   typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;
   state_t                 state_q, state_d;
   logic [IW-1:0]          g_q, g_d, ptr_q, ptr_d, pick, nxt;
   logic [KW-1:0]          k;
   logic [7:0]             cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0] err_q, err_d, blk_q, blk_d, elig;
   logic                   found, in_bus, stb, ack, timeout;
   logic                   g_cyc, g_stb, g_act, g_we;
   logic [3:0]             g_sel;
   logic [ADDR_WIDTH-1:0]  g_adr;
   logic [31:0]            g_dat;
   assign elig    = bus.m_cyc_i & bus.m_active_i & ~blk_q;
   assign in_bus  = state_q == BUS;
   assign ack     = bus.rambus_wb_ack_i;
   assign stb     = in_bus & g_stb & g_act;
   assign timeout = stb & ~ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
   assign nxt     = g_q == IW'(NUM_MASTERS - 1) ? '0 : g_q + 1'b1;
   always_comb begin
      g_cyc = 1'b0;
      g_stb = 1'b0;
      g_act = 1'b0;
      g_we  = 1'b0;
      g_sel = '0;
      g_adr = '0;
      g_dat = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (g_q == IW'(i)) begin
            g_cyc = bus.m_cyc_i[i];
            g_stb = bus.m_stb_i[i];
            g_act = bus.m_active_i[i];
            g_we  = bus.m_we_i[i];
            g_sel = bus.m_sel_i[4*i +: 4];
            g_adr = bus.m_adr_i[ADDR_WIDTH*i +: ADDR_WIDTH];
            g_dat = bus.m_dat_i[32*i +: 32];
         end
   end
   // scan from the highest offset down so the candidate nearest ptr wins
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      k     = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         k = KW'(ptr_q) + KW'(i);
         k = k >= KW'(NUM_MASTERS) ? k - KW'(NUM_MASTERS) : k;
         if (elig[k[IW-1:0]]) begin
            found = 1'b1;
            pick  = k[IW-1:0];
         end
      end
   end
   // a timed-out master stays blocked until its cyc has been seen low at an edge
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      cnt_d   = '0;
      err_d   = '0;
      blk_d   = blk_q & bus.m_cyc_i;
      case (state_q)
         IDLE: begin
            state_d = found ? BUS : IDLE;
            g_d     = found ? pick : g_q;
         end
         BUS: begin
            cnt_d = stb & ~ack ? cnt_q + 8'd1 : '0;
            if (timeout | ~g_cyc | ~g_act) begin
               state_d = RELEASE;
               ptr_d   = nxt;
               cnt_d   = '0;
            end
            if (timeout) begin
               err_d[g_q] = 1'b1;
               blk_d[g_q] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         state_q <= IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         blk_q   <= blk_d;
      end
   assign bus.rambus_wb_cyc_o = in_bus;
   assign bus.rambus_wb_stb_o = stb;
   assign bus.rambus_wb_we_o  = in_bus & g_we;
   assign bus.rambus_wb_sel_o = in_bus ? g_sel : '0;
   assign bus.rambus_wb_adr_o = in_bus ? g_adr : '0;
   assign bus.rambus_wb_dat_o = in_bus ? g_dat : '0;
   assign bus.m_ack_o         = in_bus ? NUM_MASTERS'(ack) << g_q : '0;
   assign bus.m_err_o         = err_q;
   assign bus.m_dat_o         = bus.rambus_wb_dat_i;
endmodule

// File: tb/tb_rambus_arbiter.sv
// tb_rambus_arbiter: directed scoreboard bench for the round-robin rambus arbiter
module tb_rambus_arbiter;
   localparam int NM = 2;
   localparam int AW = 10;
   typedef struct packed {
      logic [1:0]    m;
      logic          we;
      logic [3:0]    sel;
      logic [AW-1:0] adr;
      logic [31:0]   dat;
   } txn_t;
   logic wb_clk_i = 1'b0;
   logic wb_rst_i;
   int   compared = 0;
   int   mismatched = 0;
   txn_t sb[$];
   rambus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW)) bus ();
   rambus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
      .wb_clk_i(wb_clk_i),
      .wb_rst_i(wb_rst_i),
      .bus     (bus)
   );
   always #5 wb_clk_i = ~wb_clk_i;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_off(input string tag);
      chk(tag, {bus.rambus_wb_cyc_o, bus.rambus_wb_stb_o, bus.rambus_wb_we_o, bus.rambus_wb_sel_o,
                bus.rambus_wb_adr_o, bus.rambus_wb_dat_o, bus.m_ack_o, bus.m_err_o}, 64'd0);
   endtask
   task automatic tick();
      @(posedge wb_clk_i);
      #2;
   endtask
   task automatic req(input int m, input logic we, input logic [AW-1:0] adr, input logic [31:0] dat, input bit push);
      bus.m_cyc_i[m] = 1'b1;
      bus.m_stb_i[m] = 1'b1;
      bus.m_we_i[m] = we;
      bus.m_sel_i[4*m +: 4] = 4'hF;
      bus.m_adr_i[AW*m +: AW] = adr;
      bus.m_dat_i[32*m +: 32] = dat;
      if (push) sb.push_back('{m: 2'(m), we: we, sel: 4'hF, adr: adr, dat: dat});
   endtask
   task automatic drop(input int m);
      bus.m_cyc_i[m] = 1'b0;
      bus.m_stb_i[m] = 1'b0;
      bus.m_we_i[m] = 1'b0;
   endtask
   task automatic ram_ack(input int m, input logic [31:0] rdata);
      txn_t e = '0;
      int   idx = -1;
      int   n = 0;
      #1;
      while (bus.rambus_wb_stb_o !== 1'b1 && n < 20) begin
         tick();
         #1;
         n++;
      end
      chk("stb_wait", bus.rambus_wb_stb_o, 1);
      foreach (sb[i]) if (idx < 0 && sb[i].m == 2'(m)) idx = i;
      chk("sb_entry", idx >= 0, 1);
      if (idx >= 0) e = sb[idx];
      bus.rambus_wb_ack_i = 1'b1;
      bus.rambus_wb_dat_i = rdata;
      #1;
      chk("cyc_o", bus.rambus_wb_cyc_o, 1);
      chk("we_o", bus.rambus_wb_we_o, e.we);
      chk("sel_o", bus.rambus_wb_sel_o, e.sel);
      chk("adr_o", bus.rambus_wb_adr_o, e.adr);
      chk("dat_o", bus.rambus_wb_dat_o, e.dat);
      chk("m_ack", bus.m_ack_o, 64'd1 << m);
      chk("m_dat", bus.m_dat_o, rdata);
      if (idx >= 0) sb.delete(idx);
      tick();
      bus.rambus_wb_ack_i = 1'b0;
   endtask
   initial begin
      wb_rst_i = 1'b1;
      bus.m_active_i = '0;
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_we_i = '0;
      bus.m_sel_i = '0;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.rambus_wb_ack_i = 1'b0;
      bus.rambus_wb_dat_i = '0;
      repeat (2) tick();
      #1 chk_off("reset_state");
      tick();
      wb_rst_i = 1'b0;
      tick();
      // single read by m0, ack on cycle 3
      bus.m_active_i = 2'b11;
      req(0, 1'b0, 10'h004, 32'h0, 1'b1);
      #1 chk("read_c0_cyc", bus.rambus_wb_cyc_o, 0);
      tick();
      #1 chk("read_c1_cyc", bus.rambus_wb_cyc_o, 1);
      chk("read_c1_ack", bus.m_ack_o, 0);
      tick();
      tick();
      ram_ack(0, 32'hA5A5_0001);
      drop(0);
      #1 chk("read_ack_pulse", bus.m_ack_o, 0);
      tick();
      #1 chk("read_release", bus.rambus_wb_cyc_o, 0);
      tick();
      // inactive gating: m0 never granted, m1 served
      bus.m_active_i = 2'b10;
      req(0, 1'b0, 10'h010, 32'h0, 1'b0);
      repeat (3) tick();
      #1 chk("gate_m0", bus.rambus_wb_cyc_o, 0);
      req(1, 1'b1, 10'h020, 32'hDEAD_BEEF, 1'b1);
      ram_ack(1, 32'h0);
      drop(1);
      drop(0);
      tick();
      tick();
      bus.m_active_i = 2'b11;
      // contention with ptr=0, then m0 re-requests while m1 still waits
      req(0, 1'b0, 10'h030, 32'h0, 1'b1);
      req(1, 1'b0, 10'h034, 32'h0, 1'b1);
      ram_ack(0, 32'h0000_0A0A);
      drop(0);
      tick();
      #1 chk("cont_gap", bus.rambus_wb_cyc_o, 0);
      req(0, 1'b0, 10'h038, 32'h0, 1'b1);
      ram_ack(1, 32'h0000_0B0B);
      drop(1);
      ram_ack(0, 32'h0000_0C0C);
      drop(0);
      tick();
      tick();
      // burst of four writes under one cyc while m1 waits
      req(0, 1'b1, 10'h000, 32'h11, 1'b1);
      ram_ack(0, 32'h0);
      req(1, 1'b0, 10'h040, 32'h0, 1'b1);
      req(0, 1'b1, 10'h004, 32'h22, 1'b1);
      ram_ack(0, 32'h0);
      req(0, 1'b1, 10'h008, 32'h33, 1'b1);
      ram_ack(0, 32'h0);
      req(0, 1'b1, 10'h00C, 32'h44, 1'b1);
      ram_ack(0, 32'h0);
      drop(0);
      ram_ack(1, 32'h0000_0D0D);
      drop(1);
      tick();
      tick();
      // timeout with RAM silent, late ack in RELEASE, m1 pending
      req(0, 1'b0, 10'h050, 32'h0, 1'b0);
      tick();
      req(1, 1'b0, 10'h060, 32'h0, 1'b1);
      repeat (7) tick();
      #1 chk("to_no_err_yet", bus.m_err_o, 0);
      chk("to_cyc_held", bus.rambus_wb_cyc_o, 1);
      tick();
      bus.rambus_wb_ack_i = 1'b1;
      #1 chk("to_err", bus.m_err_o, 2'b01);
      chk("to_cyc_drop", bus.rambus_wb_cyc_o, 0);
      chk("to_stb_drop", bus.rambus_wb_stb_o, 0);
      chk("late_ack", bus.m_ack_o, 0);
      tick();
      bus.rambus_wb_ack_i = 1'b0;
      #1 chk("to_err_pulse", bus.m_err_o, 0);
      tick();
      #1 chk("to_m1_grant", bus.rambus_wb_cyc_o, 1);
      ram_ack(1, 32'h0000_0E0E);
      drop(1);
      repeat (3) tick();
      #1 chk("to_m0_blocked", bus.rambus_wb_cyc_o, 0);
      drop(0);
      tick();
      req(0, 1'b0, 10'h070, 32'h0, 1'b1);
      ram_ack(0, 32'h0000_0F0F);
      drop(0);
      // asynchronous reset while m1 writes, then m0 wins from ptr=0
      req(1, 1'b1, 10'h080, 32'h1234_5678, 1'b0);
      repeat (3) tick();
      req(0, 1'b0, 10'h090, 32'h0, 1'b1);
      #1 chk("rst_pre_stb", bus.rambus_wb_stb_o, 1);
      chk("rst_pre_ack", bus.m_ack_o, 0);
      wb_rst_i = 1'b1;
      #1 chk_off("rst_async");
      tick();
      wb_rst_i = 1'b0;
      ram_ack(0, 32'h5555_AAAA);
      drop(0);
      drop(1);
      tick();
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
